// File: rtl/bsync_trigger_gen.sv
// Burst trigger generator: emits pulses phase-locked to BSYNC rising edges
// plus a fixed cycle offset, under arm/abort control.
module bsync_trigger_gen #(
    parameter int DELAY_WIDTH = 16,
    parameter int COUNT_WIDTH = 8,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   bsync_in,
    input  logic                   bsync_ready,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   mode,
    input  logic [COUNT_WIDTH-1:0] pulse_count,
    input  logic [DELAY_WIDTH-1:0] trig_delay,
    input  logic [LEN_WIDTH-1:0]   pulse_len,
    output logic                   trig_out,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [15:0]            trig_total,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        PULSE = 3'd3
    } state_t;

    state_t                 state_reg;
    logic                   bsync_q_reg;
    logic                   mode_reg;
    logic [COUNT_WIDTH-1:0] remain_reg;
    logic [DELAY_WIDTH-1:0] delay_reg;
    logic [DELAY_WIDTH-1:0] delay_cnt_reg;
    logic [LEN_WIDTH-1:0]   len_reg;
    logic [LEN_WIDTH-1:0]   len_cnt_reg;
    logic                   trig_reg;
    logic                   done_reg;
    logic                   error_reg;
    logic [15:0]            total_reg;

    logic bsync_rise;
    logic last_pulse;

    assign bsync_rise = bsync_in & ~bsync_q_reg;
    assign last_pulse = ~mode_reg && (remain_reg <= COUNT_WIDTH'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            bsync_q_reg   <= 1'b0;
            mode_reg      <= 1'b0;
            remain_reg    <= '0;
            delay_reg     <= '0;
            delay_cnt_reg <= '0;
            len_reg       <= '0;
            len_cnt_reg   <= '0;
            trig_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            total_reg     <= '0;
        end else begin
            bsync_q_reg <= bsync_in;
            done_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arm) begin
                        if (bsync_ready) begin
                            mode_reg   <= mode;
                            remain_reg <= (pulse_count == '0) ? COUNT_WIDTH'(1) : pulse_count;
                            delay_reg  <= trig_delay;
                            len_reg    <= (pulse_len == '0) ? LEN_WIDTH'(1) : pulse_len;
                            error_reg  <= 1'b0;
                            state_reg  <= ARMED;
                        end else begin
                            error_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Losing calibration outranks abort so the error is never masked.
                    if (!bsync_ready) begin
                        state_reg <= IDLE;
                        trig_reg  <= 1'b0;
                        error_reg <= 1'b1;
                    end else if (abort) begin
                        state_reg <= IDLE;
                        trig_reg  <= 1'b0;
                    end else begin
                        case (state_reg)
                            ARMED: begin
                                if (bsync_rise) begin
                                    if (delay_reg == '0) begin
                                        state_reg   <= PULSE;
                                        trig_reg    <= 1'b1;
                                        total_reg   <= total_reg + 16'd1;
                                        len_cnt_reg <= len_reg - LEN_WIDTH'(1);
                                    end else begin
                                        state_reg     <= DELAY;
                                        delay_cnt_reg <= delay_reg - DELAY_WIDTH'(1);
                                    end
                                end
                            end
                            DELAY: begin
                                if (delay_cnt_reg == '0) begin
                                    state_reg   <= PULSE;
                                    trig_reg    <= 1'b1;
                                    total_reg   <= total_reg + 16'd1;
                                    len_cnt_reg <= len_reg - LEN_WIDTH'(1);
                                end else begin
                                    delay_cnt_reg <= delay_cnt_reg - DELAY_WIDTH'(1);
                                end
                            end
                            PULSE: begin
                                if (len_cnt_reg == '0) begin
                                    trig_reg <= 1'b0;
                                    if (!mode_reg) begin
                                        remain_reg <= remain_reg - COUNT_WIDTH'(1);
                                    end
                                    if (last_pulse) begin
                                        state_reg <= IDLE;
                                        done_reg  <= 1'b1;
                                    end else begin
                                        state_reg <= ARMED;
                                    end
                                end else begin
                                    len_cnt_reg <= len_cnt_reg - LEN_WIDTH'(1);
                                end
                            end
                            default: state_reg <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign trig_out   = trig_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign error      = error_reg;
    assign trig_total = total_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_bsync_trigger_gen.sv
// Bench for bsync_trigger_gen: timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then random bursts.
module tb_bsync_trigger_gen;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          bsync_in = 1'b0;
    logic          bsync_ready = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          mode = 1'b0;
    logic [CW-1:0] pulse_count = '0;
    logic [DW-1:0] trig_delay = '0;
    logic [LW-1:0] pulse_len = '0;
    logic          trig_out, busy, done, error;
    logic [15:0]   trig_total;
    logic [2:0]    state;

    bsync_trigger_gen #(.DELAY_WIDTH(DW), .COUNT_WIDTH(CW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rstn(rstn), .bsync_in(bsync_in), .bsync_ready(bsync_ready),
        .arm(arm), .abort(abort), .mode(mode), .pulse_count(pulse_count),
        .trig_delay(trig_delay), .pulse_len(pulse_len), .trig_out(trig_out),
        .busy(busy), .done(done), .error(error), .trig_total(trig_total), .state(state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n = 0;
    int bs_period = 32;
    int bs_phase = 0;

    // Reference model: a burst is a sequence of (edge, rise, fall) timestamps.
    bit          m_prev, m_active, m_wait, m_mode, m_trig, m_done, m_err;
    int          m_left, m_delay, m_len, m_rise, m_fall;
    logic [15:0] m_total;

    int last_edge = -1000;
    int last_rise_n = 0;
    bit prev_obs = 1'b0;
    int scen_rises, done_cnt, tot0;
    int rise_times[$];
    int obs_delay[$];
    int obs_width[$];

    function automatic logic [2:0] m_state();
        if (!m_active)   return 3'd0;
        if (m_wait)      return 3'd1;
        if (n < m_rise)  return 3'd2;
        return 3'd3;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_active = 0; m_wait = 0; m_mode = 0; m_trig = 0;
        m_done = 0; m_err = 0; m_left = 0; m_delay = 0; m_len = 0;
        m_rise = 0; m_fall = 0; m_total = 16'd0;
    endtask

    task automatic model_update();
        bit e;
        e = bsync_in && !m_prev;
        m_prev = bsync_in;
        if (e) last_edge = n;
        m_done = 0;
        if (!m_active) begin
            if (arm) begin
                if (bsync_ready) begin
                    m_mode = mode;
                    m_left = (pulse_count == 0) ? 1 : int'(pulse_count);
                    m_delay = int'(trig_delay);
                    m_len = (pulse_len == 0) ? 1 : int'(pulse_len);
                    m_err = 0; m_active = 1; m_wait = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (!bsync_ready) begin
            m_active = 0; m_trig = 0; m_err = 1;
        end else if (abort) begin
            m_active = 0; m_trig = 0;
        end else begin
            if (m_wait && e) begin
                m_wait = 0;
                m_rise = n + m_delay;
                m_fall = m_rise + m_len;
            end
            if (!m_wait) begin
                if (n == m_rise) begin
                    m_trig = 1;
                    m_total = m_total + 16'd1;
                end
                if (n == m_fall) begin
                    m_trig = 0;
                    if (!m_mode) m_left = m_left - 1;
                    if (!m_mode && m_left == 0) begin
                        m_active = 0; m_done = 1;
                    end else begin
                        m_wait = 1;
                    end
                end
            end
        end
    endtask

    task automatic check();
        logic [22:0] act, exp;
        act = {trig_out, busy, done, error, trig_total, state};
        exp = {m_trig, m_active, m_done, m_err, m_total, m_state()};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL cycle n=%0d: got trig=%b busy=%b done=%b err=%b total=%0d state=%0d, expected trig=%b busy=%b done=%b err=%b total=%0d state=%0d",
                     n, trig_out, busy, done, error, trig_total, state,
                     m_trig, m_active, m_done, m_err, m_total, m_state());
        end
        if (trig_out && !prev_obs) begin
            obs_delay.push_back(n - last_edge);
            rise_times.push_back(n);
            last_rise_n = n;
            scen_rises++;
        end
        if (!trig_out && prev_obs) obs_width.push_back(n - last_rise_n);
        if (done) done_cnt++;
        prev_obs = trig_out;
    endtask

    task automatic pin(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        bsync_in = (bs_phase < bs_period / 2);
        @(posedge clk);
        n++;
        model_update();
        bs_phase = (bs_phase + 1) % bs_period;
        @(negedge clk);
        check();
        arm = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_idle(input int maxc, input string name);
        int c;
        c = 0;
        do begin
            cycle();
            c++;
        end while (busy && c < maxc);
        if (busy) begin
            tests++; fails++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, expected 0", name, busy, c);
        end
    endtask

    task automatic scen_start();
        scen_rises = 0; done_cnt = 0; tot0 = int'(trig_total);
        obs_delay.delete(); obs_width.delete(); rise_times.delete();
    endtask

    task automatic async_reset_check(input string tag);
        #2 rstn = 1'b0;
        #1;
        pin({tag, "_trig"}, int'(trig_out), 0);
        pin({tag, "_busy"}, int'(busy), 0);
        pin({tag, "_done"}, int'(done), 0);
        pin({tag, "_error"}, int'(error), 0);
        pin({tag, "_total"}, int'(trig_total), 0);
        pin({tag, "_state"}, int'(state), 0);
        model_reset();
        prev_obs = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic set_params(input bit md, input int cnt, input int dly, input int len);
        mode = md;
        pulse_count = CW'(cnt);
        trig_delay = DW'(dly);
        pulse_len = LW'(len);
    endtask

    task automatic txn_line(input string name);
        $display("[TB] %s: mode=%0d cnt=%0d delay=%0d len=%0d rises=%0d done=%0d total=%0d err=%0d",
                 name, mode, pulse_count, trig_delay, pulse_len, scen_rises, done_cnt, trig_total, error);
    endtask

    initial begin
        int c;
        int abort_at;
        int periods[5];
        periods = '{8, 12, 16, 20, 32};

        model_reset();
        async_reset_check("reset");
        bsync_ready = 1'b1;
        repeat (3) cycle();

        // Normal burst: 3 pulses, delay 5, width 4.
        scen_start();
        bs_period = 32; bs_phase = 16;
        set_params(1'b0, 3, 5, 4);
        arm = 1'b1;
        cycle();
        run_idle(300, "normal");
        pin("normal_rises", scen_rises, 3);
        foreach (obs_delay[i]) pin("normal_delay", obs_delay[i], 5);
        foreach (obs_width[i]) pin("normal_width", obs_width[i], 4);
        pin("normal_done", done_cnt, 1);
        pin("normal_total", int'(trig_total), 3);
        pin("normal_busy", int'(busy), 0);
        txn_line("normal");

        // All-zero parameters: one single-cycle pulse on the detecting edge.
        scen_start();
        set_params(1'b0, 0, 0, 0);
        arm = 1'b1;
        cycle();
        run_idle(100, "zeros");
        pin("zeros_rises", scen_rises, 1);
        if (obs_delay.size() > 0) pin("zeros_delay", obs_delay[0], 0);
        if (obs_width.size() > 0) pin("zeros_width", obs_width[0], 1);
        pin("zeros_done", done_cnt, 1);
        pin("zeros_total", int'(trig_total), 4);
        txn_line("zeros");

        // Continuous mode, abort during the 11th delay.
        scen_start();
        bs_period = 16; bs_phase = 0;
        set_params(1'b1, 1, 2, 2);
        arm = 1'b1;
        cycle();
        c = 0;
        while (!(scen_rises == 10 && state == 3'd2) && c < 400) begin
            cycle();
            c++;
        end
        pin("cont_reached_delay", int'(state), 2);
        abort = 1'b1;
        cycle();
        pin("cont_rises", scen_rises, 10);
        pin("cont_total", int'(trig_total) - tot0, 10);
        pin("cont_state", int'(state), 0);
        pin("cont_trig", int'(trig_out), 0);
        pin("cont_done", done_cnt, 0);
        repeat (4) cycle();
        txn_line("continuous");

        // Arm while not ready, then a good arm.
        scen_start();
        bsync_ready = 1'b0;
        set_params(1'b0, 1, 3, 2);
        arm = 1'b1;
        cycle();
        pin("notready_error", int'(error), 1);
        pin("notready_state", int'(state), 0);
        bsync_ready = 1'b1;
        arm = 1'b1;
        cycle();
        pin("rearm_error", int'(error), 0);
        pin("rearm_busy", int'(busy), 1);
        run_idle(100, "rearm");
        pin("rearm_done", done_cnt, 1);
        txn_line("notready_rearm");

        // Ready loss during pulse 2 of 4.
        scen_start();
        bs_period = 32;
        set_params(1'b0, 4, 1, 6);
        arm = 1'b1;
        cycle();
        c = 0;
        while (!(scen_rises == 2 && trig_out) && c < 300) begin
            cycle();
            c++;
        end
        pin("readyloss_in_pulse", int'(state), 3);
        cycle();
        bsync_ready = 1'b0;
        cycle();
        pin("readyloss_trig", int'(trig_out), 0);
        pin("readyloss_state", int'(state), 0);
        pin("readyloss_error", int'(error), 1);
        bsync_ready = 1'b1;
        repeat (3) cycle();
        pin("readyloss_done", done_cnt, 0);
        txn_line("ready_loss");

        // Pulse longer than the BSYNC period, then async reset mid-burst.
        scen_start();
        bs_period = 32; bs_phase = 20;
        set_params(1'b0, 3, 3, 40);
        arm = 1'b1;
        cycle();
        c = 0;
        while (scen_rises < 2 && c < 300) begin
            cycle();
            c++;
        end
        pin("long_rises", scen_rises, 2);
        if (rise_times.size() >= 2) pin("long_spacing", rise_times[1] - rise_times[0], 64);
        if (obs_delay.size() >= 2) pin("long_delay2", obs_delay[1], 3);
        if (obs_width.size() >= 1) pin("long_width", obs_width[0], 40);
        repeat (5) cycle();
        txn_line("long_pulse");
        async_reset_check("midburst_reset");
        repeat (2) cycle();

        // Randomised bursts with stray arms, aborts and ready drops.
        for (int t = 0; t < 30; t++) begin
            scen_start();
            bs_period = periods[$urandom_range(0, 4)];
            bs_phase = bs_phase % bs_period;
            set_params($urandom_range(0, 3) == 0, $urandom_range(0, 4),
                       $urandom_range(0, 20), $urandom_range(0, 20));
            repeat ($urandom_range(0, 5)) cycle();
            if ($urandom_range(0, 5) == 0) begin
                bsync_ready = 1'b0;
                arm = 1'b1;
                cycle();
                bsync_ready = 1'b1;
            end
            arm = 1'b1;
            abort = ($urandom_range(0, 7) == 0);
            cycle();
            abort_at = int'($urandom_range(20, 250));
            c = 0;
            while (busy && c < 600) begin
                if ($urandom_range(0, 49) == 0) arm = 1'b1;
                if (mode ? (c == abort_at) : ($urandom_range(0, 199) == 0)) abort = 1'b1;
                if ($urandom_range(0, 299) == 0) bsync_ready = 1'b0;
                trig_delay = DW'($urandom);
                pulse_len = LW'($urandom);
                pulse_count = CW'($urandom);
                cycle();
                bsync_ready = 1'b1;
                c++;
            end
            if (busy) begin
                abort = 1'b1;
                cycle();
            end
            txn_line($sformatf("random%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
